seg7_scan_display: RTL

- Reader end of the 8-bit counter output bus: takes the binary count value (0–255) and shows it in decimal on a 3-digit multiplexed common-anode 7-segment display.
- Contains a sequential double-dabble binary-to-BCD converter and a time-multiplexed digit scanner, with optional leading-zero blanking.
- Sits beside the 8-bit counter in the top level; connects directly to board anode/segment pins.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_scan_display_bin2bcd.sv | 70 +++++++
 rtl/seg7_scan_display.sv | 104 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment display.
// Segment patterns are active-high, written as seg[6:0] = {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} conv_state_t;

  localparam int NDIG = 3;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Nibbles 10..15 are not valid BCD and show as blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd.sv
// Sequential double-dabble converter: 8-bit binary to 3 BCD digits in
// 10 cycles (LOAD, 8 x CONV, DONE). bcd holds the last completed result.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output conv_state_t state
);

  logic [19:0] shreg;
  logic [19:0] adj;
  logic [2:0]  cnt;

  always_comb begin
    adj = shreg;
    for (int i = 0; i < NDIG; i++) begin
      if (shreg[8 + 4*i +: 4] >= 4'd5)
        adj[8 + 4*i +: 4] = shreg[8 + 4*i +: 4] + 4'd3;
    end
  end

  // done is high during the DONE cycle so the caller can mark the result valid
  // on the same edge that publishes bcd.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg <= {12'b0, bin};
          cnt   <= '0;
          state <= CONV;
        end
        CONV: begin
          shreg <= adj << 1;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          bcd   <= shreg[19:8];
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Shows an 8-bit count in decimal on a 3-digit multiplexed 7-segment display:
// change detector, BCD conversion, digit scanner and registered pin drivers.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  // SCAN_DIV must be at least 2 so the prescaler has a real counter.
  localparam int unsigned SCAN_DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned PW       = $clog2(SCAN_DIV);

  logic [2:0] an_off;
  logic [6:0] seg_off;
  assign an_off  = ACTIVE_LOW ? 3'b111 : 3'b000;
  assign seg_off = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  assign dp      = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic        valid;
  logic [7:0]  last_value;
  logic        start;
  logic        done;
  logic [11:0] bcd;
  conv_state_t conv_state;

  // A conversion is requested after reset (valid clear) or whenever the input
  // differs from the value captured by the previous LOAD.
  assign start = (conv_state == IDLE) && (!valid || (value != last_value));

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .state (conv_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= 1'b0;
      last_value <= '0;
    end else begin
      if (conv_state == LOAD) last_value <= value;
      if (done) valid <= 1'b1;
    end
  end

  logic [PW-1:0] presc;
  logic [1:0]    idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  logic [3:0] nib;
  logic       blank;
  logic [2:0] an_on;
  logic [6:0] seg_on;

  always_comb begin
    case (idx)
      2'd0:    nib = bcd[3:0];
      2'd1:    nib = bcd[7:4];
      default: nib = bcd[11:8];
    endcase
    blank  = BLANK_LZ && (((idx == 2'd2) && (bcd[11:8] == 4'd0)) ||
                          ((idx == 2'd1) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)));
    an_on  = blank ? 3'b000 : (3'b001 << idx);
    seg_on = blank ? SEG_BLANK : seg_encode(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= an_off;
      seg <= seg_off;
    end else begin
      an  <= ACTIVE_LOW ? ~an_on : an_on;
      seg <= ACTIVE_LOW ? ~seg_on : seg_on;
    end
  end

endmodule
